rct_pair_scheduler: RTL and testbench

Shares one `forward_rct` datapath between two pixel-pair sources, e.g. two sensor models, with line-granular round-robin arbitration. It registers the granted pair into the transform input. It tracks column, row and frame position per source. It emits a tag stream (source, end-of-line, end-of-frame) time-aligned with `forward_rct` output, so downstream wavelet/display logic can demultiplex the Y/Cb/Cr results.

---
 rtl/rct_pair_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_rct_pair_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rct_pair_scheduler.sv
// Line-granular round-robin scheduler feeding one forward_rct from two pixel-pair sources,
// with a tag stream aligned to the transform output. Optional sync checker: RCT_SCHED_SYNC_CHECK_EN.
module rct_pair_scheduler #(
   parameter int IMG_PIX_W = 8,
   parameter int SIZE      = 64,
   parameter int RCT_LAT   = 2
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   s0_valid,
   output logic                   s0_ready,
   input  logic [6*IMG_PIX_W-1:0] s0_pair,
   input  logic                   s1_valid,
   output logic                   s1_ready,
   input  logic [6*IMG_PIX_W-1:0] s1_pair,
   output logic                   rct_in_valid,
   output logic [6*IMG_PIX_W-1:0] rct_pair,
   input  logic                   rct_out_valid,
   output logic                   tag_valid,
   output logic                   tag_src,
   output logic                   tag_eol,
   output logic                   tag_eof,
   output logic [1:0]             frame_done,
   output logic                   err_sync
);

   localparam int PAIR_W = 6 * IMG_PIX_W;
   localparam int HALF   = SIZE / 2;
   localparam int COL_W  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int ROW_W  = $clog2(SIZE);

   typedef enum logic {
      IDLE = 1'b0,
      LINE = 1'b1
   } state_t;

   state_t            state_r, state_nxt_s;
   logic              grant_r, grant_nxt_s;
   logic              last_src_r, last_src_nxt_s;
   logic              s0_ready_r, s1_ready_r;
   logic [COL_W-1:0]  col_r [2];
   logic [ROW_W-1:0]  row_r [2];
   logic              sel_valid_s;
   logic [PAIR_W-1:0] sel_pair_s;
   logic              xfer_s, eol_s, eof_s;
   logic              rct_in_valid_r;
   logic [PAIR_W-1:0] rct_pair_r;
   logic              in_src_r, in_eol_r, in_eof_r;
   logic [1:0]        frame_done_r;
   logic [3:0]        pipe_r [RCT_LAT];

   // Granted-source mux and line/frame boundary decode for the current transfer.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_pair_s  = '0;
      if (grant_r) begin
         sel_valid_s = s1_valid;
         sel_pair_s  = s1_pair;
      end else begin
         sel_valid_s = s0_valid;
         sel_pair_s  = s0_pair;
      end
      xfer_s = (state_r == LINE) && sel_valid_s;
      eol_s  = (col_r[grant_r] == COL_W'(HALF - 1));
      eof_s  = eol_s && (row_r[grant_r] == ROW_W'(SIZE - 1));
   end

   // Arbitration next-state: ties go to the source that did not own the previous line.
   always_comb begin
      state_nxt_s    = state_r;
      grant_nxt_s    = grant_r;
      last_src_nxt_s = last_src_r;
      case (state_r)
         IDLE: begin
            if (s0_valid && s1_valid) begin
               grant_nxt_s = ~last_src_r;
               state_nxt_s = LINE;
            end else if (s0_valid) begin
               grant_nxt_s = 1'b0;
               state_nxt_s = LINE;
            end else if (s1_valid) begin
               grant_nxt_s = 1'b1;
               state_nxt_s = LINE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LINE: begin
            if (xfer_s && eol_s) begin
               state_nxt_s    = IDLE;
               last_src_nxt_s = grant_r;
            end else begin
               state_nxt_s = LINE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM registers; ready is registered from the next grant so it never depends on valid.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r    <= IDLE;
         grant_r    <= 1'b0;
         last_src_r <= 1'b1;
         s0_ready_r <= 1'b0;
         s1_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         grant_r    <= grant_nxt_s;
         last_src_r <= last_src_nxt_s;
         s0_ready_r <= (state_nxt_s == LINE) && !grant_nxt_s;
         s1_ready_r <= (state_nxt_s == LINE) && grant_nxt_s;
      end
   end

   // Per-source column/row position.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < 2; i++) begin
            col_r[i] <= '0;
            row_r[i] <= '0;
         end
      end else if (xfer_s) begin
         if (eol_s) begin
            col_r[grant_r] <= '0;
            row_r[grant_r] <= eof_s ? '0 : row_r[grant_r] + ROW_W'(1);
         end else begin
            col_r[grant_r] <= col_r[grant_r] + COL_W'(1);
         end
      end
   end

   // Transform input register plus the tag fields entering the delay line.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rct_in_valid_r <= 1'b0;
         rct_pair_r     <= '0;
         in_src_r       <= 1'b0;
         in_eol_r       <= 1'b0;
         in_eof_r       <= 1'b0;
         frame_done_r   <= 2'b00;
      end else begin
         rct_in_valid_r <= xfer_s;
         in_src_r       <= xfer_s && grant_r;
         in_eol_r       <= xfer_s && eol_s;
         in_eof_r       <= xfer_s && eof_s;
         frame_done_r   <= {xfer_s && eof_s && grant_r, xfer_s && eof_s && !grant_r};
         if (xfer_s) begin
            rct_pair_r <= sel_pair_s;
         end
      end
   end

   // Tag delay line matching the forward_rct latency.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < RCT_LAT; i++) begin
            pipe_r[i] <= 4'b0000;
         end
      end else begin
         pipe_r[0] <= {rct_in_valid_r, in_src_r, in_eol_r, in_eof_r};
         for (int i = 1; i < RCT_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign s0_ready     = s0_ready_r;
   assign s1_ready     = s1_ready_r;
   assign rct_in_valid = rct_in_valid_r;
   assign rct_pair     = rct_pair_r;
   assign frame_done   = frame_done_r;
   assign tag_valid    = pipe_r[RCT_LAT-1][3];
   assign tag_src      = pipe_r[RCT_LAT-1][2];
   assign tag_eol      = pipe_r[RCT_LAT-1][1];
   assign tag_eof      = pipe_r[RCT_LAT-1][0];

`ifdef RCT_SCHED_SYNC_CHECK_EN
   logic err_sync_r;

   // Sticky flag when the transform output disagrees with the expected tag.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_sync_r <= 1'b0;
      end else if (rct_out_valid != pipe_r[RCT_LAT-1][3]) begin
         err_sync_r <= 1'b1;
      end
   end

   assign err_sync = err_sync_r;
`else
   logic unused_out_valid_s;
   assign unused_out_valid_s = rct_out_valid;
   assign err_sync           = 1'b0;
`endif

endmodule

// File: tb/tb_rct_pair_scheduler.sv
// Self-checking bench for rct_pair_scheduler (SIZE=4, RCT_LAT=2) against a pair-count based
// reference model; forward_rct is modelled as a pure valid delay.
module tb_rct_pair_scheduler;

   localparam int W    = 8;
   localparam int SIZE = 4;
   localparam int LAT  = 2;
   localparam int PW   = 6 * W;
   localparam int HALF = SIZE / 2;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          s0_valid, s1_valid;
   logic          s0_ready, s1_ready;
   logic [PW-1:0] s0_pair, s1_pair;
   logic          rct_in_valid;
   logic [PW-1:0] rct_pair;
   logic          rct_out_valid;
   logic          tag_valid, tag_src, tag_eol, tag_eof;
   logic [1:0]    frame_done;
   logic          err_sync;

   logic [LAT-1:0] lat_sr;
   logic           spur;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int   due;
      logic src;
      logic eol;
      logic eof;
   } tag_t;

   tag_t          tq[$];
   int            mgrant;
   int            mlast;
   int            cnt[2];
   logic [PW-1:0] m_pair;
   logic          m_inv;
   logic [1:0]    m_fd;

   rct_pair_scheduler #(.IMG_PIX_W(W), .SIZE(SIZE), .RCT_LAT(LAT)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_pair(s0_pair),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_pair(s1_pair),
      .rct_in_valid(rct_in_valid), .rct_pair(rct_pair), .rct_out_valid(rct_out_valid),
      .tag_valid(tag_valid), .tag_src(tag_src), .tag_eol(tag_eol), .tag_eof(tag_eof),
      .frame_done(frame_done), .err_sync(err_sync)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      if (HRESET) lat_sr <= '0;
      else        lat_sr <= {lat_sr[LAT-2:0], rct_in_valid};
   end
   assign rct_out_valid = lat_sr[LAT-1] | spur;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: compare DUT outputs with the model, advance the model, step the clock.
   task automatic run_cycle();
      logic [63:0] r;
      logic        er0, er1, etv, vs, eol, eof;
      int          k, src;
      r = {$urandom(), $urandom()}; s0_pair = r[PW-1:0];
      r = {$urandom(), $urandom()}; s1_pair = r[PW-1:0];
      er0 = (mgrant == 0);
      er1 = (mgrant == 1);
      n_tests++;
      if (s0_ready !== er0) begin n_fail++; $display("FAIL s0_ready cyc=%0d got=%b exp=%b", cyc, s0_ready, er0); end
      n_tests++;
      if (s1_ready !== er1) begin n_fail++; $display("FAIL s1_ready cyc=%0d got=%b exp=%b", cyc, s1_ready, er1); end
      n_tests++;
      if (rct_in_valid !== m_inv) begin n_fail++; $display("FAIL rct_in_valid cyc=%0d got=%b exp=%b", cyc, rct_in_valid, m_inv); end
      n_tests++;
      if (rct_pair !== m_pair) begin n_fail++; $display("FAIL rct_pair cyc=%0d got=%h exp=%h", cyc, rct_pair, m_pair); end
      n_tests++;
      if (frame_done !== m_fd) begin n_fail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, m_fd); end
      etv = (tq.size() > 0) && (tq[0].due == cyc);
      n_tests++;
      if (tag_valid !== etv) begin n_fail++; $display("FAIL tag_valid cyc=%0d got=%b exp=%b", cyc, tag_valid, etv); end
      if (etv) begin
         n_tests++;
         if ({tag_src, tag_eol, tag_eof} !== {tq[0].src, tq[0].eol, tq[0].eof}) begin
            n_fail++;
            $display("FAIL tag_fields cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tag_src, tag_eol, tag_eof,
                     tq[0].src, tq[0].eol, tq[0].eof);
         end
         void'(tq.pop_front());
      end
      m_inv = 1'b0;
      m_fd  = 2'b00;
      if (HRESET) begin
         mgrant = -1; mlast = 1; cnt[0] = 0; cnt[1] = 0;
         tq.delete(); m_pair = '0;
      end else if (mgrant < 0) begin
         if (s0_valid && s1_valid) mgrant = 1 - mlast;
         else if (s0_valid)        mgrant = 0;
         else if (s1_valid)        mgrant = 1;
      end else begin
         src = mgrant;
         vs  = (src == 1) ? s1_valid : s0_valid;
         if (vs) begin
            k      = cnt[src];
            eol    = ((k % HALF) == HALF - 1);
            eof    = ((k % (HALF * SIZE)) == HALF * SIZE - 1);
            m_pair = (src == 1) ? s1_pair : s0_pair;
            m_inv  = 1'b1;
            m_fd[src] = eof;
            tq.push_back('{cyc + 1 + LAT, (src == 1), eol, eof});
            cnt[src] = k + 1;
            if (eol) begin
               mlast  = src;
               mgrant = -1;
            end
         end
      end
      @(posedge HCLK);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      HRESET = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
      run_cycle();
      HRESET = 1'b0;
      cyc = 0;
   endtask

   task automatic drain();
      s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (8) run_cycle();
   endtask

   task automatic test_reset();
      HRESET = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; spur = 1'b0;
      s0_pair = '0; s1_pair = '0;
      repeat (2) @(posedge HCLK);
      #1;
      mgrant = -1; mlast = 1; cnt[0] = 0; cnt[1] = 0; m_pair = '0; m_inv = 1'b0; m_fd = 2'b00;
      n_tests++;
      if ({s0_ready, s1_ready, rct_in_valid, tag_valid, tag_src, tag_eol, tag_eof, frame_done, err_sync} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b exp=0", {s0_ready, s1_ready, rct_in_valid, tag_valid, tag_src,
                  tag_eol, tag_eof, frame_done, err_sync});
      end
      n_tests++;
      if (rct_pair !== '0) begin n_fail++; $display("FAIL reset_pair got=%h exp=0", rct_pair); end
      HRESET = 1'b0;
      cyc = 0;
   endtask

   task automatic test_single_source();
      int acc = 0, fd = 0, neof = 0, neol = 0;
      do_reset();
      s0_valid = 1'b1; s1_valid = 1'b0;
      repeat (30) begin
         if (s0_ready && s0_valid) acc++;
         if (frame_done[0]) fd++;
         if (tag_valid && tag_eof) neof++;
         if (tag_valid && tag_eol) neol++;
         run_cycle();
      end
      n_tests++;
      if (acc != 20) begin n_fail++; $display("FAIL single_accepts got=%0d exp=20", acc); end
      n_tests++;
      if (fd != 2) begin n_fail++; $display("FAIL single_frame_done got=%0d exp=2", fd); end
      n_tests++;
      if (neof != 2) begin n_fail++; $display("FAIL single_eof_tags got=%0d exp=2", neof); end
      n_tests++;
      if (neol != 9) begin n_fail++; $display("FAIL single_eol_tags got=%0d exp=9", neol); end
      drain();
   endtask

   task automatic test_alternate();
      logic srcq[$];
      logic e;
      do_reset();
      s0_valid = 1'b1; s1_valid = 1'b1;
      repeat (30) begin
         n_tests++;
         if (s0_ready && s1_ready) begin n_fail++; $display("FAIL alt_both_ready cyc=%0d got=11 exp=not both", cyc); end
         if (tag_valid) srcq.push_back(tag_src);
         run_cycle();
      end
      n_tests++;
      if (srcq.size() < 8) begin
         n_fail++; $display("FAIL alt_tag_count got=%0d exp>=8", srcq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            e = ((i / 2) % 2) == 1;
            n_tests++;
            if (srcq[i] !== e) begin n_fail++; $display("FAIL alt_tag_src idx=%0d got=%b exp=%b", i, srcq[i], e); end
         end
      end
      drain();
   endtask

   task automatic test_stall();
      int seen = 0;
      do_reset();
      s0_valid = 1'b1; s1_valid = 1'b1;
      run_cycle();
      run_cycle();
      s0_valid = 1'b0;
      repeat (5) begin
         n_tests++;
         if ({s0_ready, s1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL stall_grant cyc=%0d got=%b exp=10", cyc, {s0_ready, s1_ready});
         end
         run_cycle();
      end
      s0_valid = 1'b1;
      repeat (6) begin
         if (cyc == 10 && tag_valid && tag_eol && !tag_src) seen++;
         run_cycle();
      end
      n_tests++;
      if (seen != 1) begin n_fail++; $display("FAIL stall_eol_tag got=%0d exp=1", seen); end
      drain();
   endtask

   task automatic test_latency();
      int acc_c = -1, in_c = -1, tv_c = -1;
      logic tsrc = 1'b1;
      do_reset();
      s1_valid = 1'b0;
      repeat (16) begin
         s0_valid = (cyc >= 9);
         if (acc_c < 0 && s0_ready && s0_valid) acc_c = cyc;
         if (in_c < 0 && rct_in_valid) in_c = cyc;
         if (tv_c < 0 && tag_valid) begin tv_c = cyc; tsrc = tag_src; end
         run_cycle();
      end
      n_tests++;
      if (acc_c != 10) begin n_fail++; $display("FAIL lat_accept got=%0d exp=10", acc_c); end
      n_tests++;
      if (in_c != 11) begin n_fail++; $display("FAIL lat_in_valid got=%0d exp=11", in_c); end
      n_tests++;
      if (tv_c != 13) begin n_fail++; $display("FAIL lat_tag_valid got=%0d exp=13", tv_c); end
      n_tests++;
      if (tsrc !== 1'b0) begin n_fail++; $display("FAIL lat_tag_src got=%b exp=0", tsrc); end
      drain();
   endtask

   task automatic test_reset_midline();
      int ntag = 0;
      logic [1:0] first = 2'b11;
      do_reset();
      s0_valid = 1'b1; s1_valid = 1'b0;
      repeat (3) run_cycle();
      HRESET = 1'b1;
      run_cycle();
      HRESET = 1'b0;
      s0_valid = 1'b0;
      repeat (6) begin
         if (tag_valid) ntag++;
         run_cycle();
      end
      n_tests++;
      if (ntag != 0) begin n_fail++; $display("FAIL rst_mid_stale_tags got=%0d exp=0", ntag); end
      s0_valid = 1'b1;
      repeat (8) begin
         if (tag_valid && first == 2'b11) first = {tag_eol, tag_eof};
         run_cycle();
      end
      n_tests++;
      if (first !== 2'b00) begin n_fail++; $display("FAIL rst_mid_first_tag got=%b exp=00", first); end
      drain();
   endtask

   task automatic test_random();
      repeat (600) begin
         s0_valid = ($urandom_range(0, 3) != 0);
         s1_valid = ($urandom_range(0, 2) != 0);
         run_cycle();
      end
      drain();
      n_tests++;
      if (tq.size() != 0) begin n_fail++; $display("FAIL random_pending_tags got=%0d exp=0", tq.size()); end
   endtask

   task automatic test_sync();
      s0_valid = 1'b0; s1_valid = 1'b0;
      run_cycle();
      spur = 1'b1;
      run_cycle();
      spur = 1'b0;
`ifdef RCT_SCHED_SYNC_CHECK_EN
      repeat (4) begin
         n_tests++;
         if (err_sync !== 1'b1) begin n_fail++; $display("FAIL sync_sticky cyc=%0d got=%b exp=1", cyc, err_sync); end
         run_cycle();
      end
      do_reset();
      n_tests++;
      if (err_sync !== 1'b0) begin n_fail++; $display("FAIL sync_cleared got=%b exp=0", err_sync); end
`else
      repeat (4) begin
         n_tests++;
         if (err_sync !== 1'b0) begin n_fail++; $display("FAIL sync_tied cyc=%0d got=%b exp=0", cyc, err_sync); end
         run_cycle();
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_alternate();
      test_stall();
      test_latency();
      test_reset_midline();
      test_random();
      test_sync();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
